// File: rtl/spi_link_pkg.sv
// -----------------------------------------------------------------------------
// spi_link_pkg
// Types shared by the SPI frame scheduler and its pixel FIFO:
//   sched_state_e : scheduler FSM states (encoding is visible on state_out)
//   fifo_entry_t  : one buffered pixel {sof, sol, data[7:0]}
// -----------------------------------------------------------------------------
package spi_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_STREAM     = 2'd2,
      ST_DRAIN      = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic       sof;   // first byte of a frame
      logic       sol;   // first byte of a decimated line
      logic [7:0] data;  // luminance
   } fifo_entry_t;

endpackage

// File: rtl/sched_fifo.sv
// -----------------------------------------------------------------------------
// sched_fifo
// Synchronous show-ahead FIFO of fifo_entry_t (10-bit) entries.
// rd_data_out always presents the head entry, so the reader captures it in the
// same cycle it pops. A write while full is accepted when a read happens in
// the same cycle.
// Ports:
//   clk_in, rst_in     : clock, synchronous active-high reset
//   wr_en_in/wr_data_in: push request and entry
//   rd_en_in           : pop request
//   rd_data_out        : head entry (valid when empty_out is low)
//   empty_out/full_out : status from the occupancy counter
// -----------------------------------------------------------------------------
module sched_fifo
   import spi_link_pkg::*;
#(
   parameter int unsigned DEPTH = 16  // power of 2, at least 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        wr_en_in,
   input  fifo_entry_t wr_data_in,
   input  logic        rd_en_in,
   output fifo_entry_t rd_data_out,
   output logic        empty_out,
   output logic        full_out
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;   // occupancy, 0..DEPTH
   fifo_entry_t   mem_q [DEPTH];

   logic wr_fire;
   logic rd_fire;

   assign empty_out   = (count_q == '0);
   assign full_out    = (count_q == (AW + 1)'(DEPTH));
   assign rd_data_out = mem_q[rd_ptr_q];

   assign rd_fire = rd_en_in && !empty_out;
   assign wr_fire = wr_en_in && (!full_out || rd_fire);

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; emptiness is defined by the
   // counter, so stale entries are never observed and the array maps to RAM.
   always_ff @(posedge clk_in) begin
      if (wr_fire) mem_q[wr_ptr_q] <= wr_data_in;
   end

endmodule

// File: rtl/spi_frame_scheduler.sv
// -----------------------------------------------------------------------------
// spi_frame_scheduler
// Picks every 2^DECIM_LOG2-th pixel in both axes from a camera stream, buffers
// the selected pixels with start-of-line/frame flags, and hands them one byte
// at a time to an SPI sender.
// Ports:
//   clk_in, rst_in        : clock, synchronous active-high reset
//   enable_in             : streaming enable (honoured at frame boundaries)
//   pixel_*_in            : camera pixel strobe, position and luminance
//   sender_ready_in       : SPI sender can take a byte
//   trigger_out           : one-cycle send strobe
//   data_out              : byte to send, held until the next trigger
//   line_start_out        : byte starts a decimated line (with trigger_out)
//   frame_start_out       : byte starts a frame (with trigger_out)
//   drop_count_out        : saturating count of pixels lost to a full FIFO
//   frame_err_out         : sticky, frame restart seen before the frame end
//   state_out             : current FSM state
// -----------------------------------------------------------------------------
module spi_frame_scheduler
   import spi_link_pkg::*;
#(
   parameter int unsigned HCOUNT_WIDTH = 10,
   parameter int unsigned VCOUNT_WIDTH = 9,
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned V_ACTIVE     = 360,
   parameter int unsigned DECIM_LOG2   = 2,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    enable_in,
   input  logic                    pixel_valid_in,
   input  logic [HCOUNT_WIDTH-1:0] pixel_hcount_in,
   input  logic [VCOUNT_WIDTH-1:0] pixel_vcount_in,
   input  logic [7:0]              pixel_data_in,
   input  logic                    sender_ready_in,
   output logic                    trigger_out,
   output logic [7:0]              data_out,
   output logic                    line_start_out,
   output logic                    frame_start_out,
   output logic [15:0]             drop_count_out,
   output logic                    frame_err_out,
   output logic [1:0]              state_out
);

   localparam int unsigned STEP       = 32'd1 << DECIM_LOG2;
   localparam int unsigned DECIM_MASK = STEP - 32'd1;

   sched_state_e state_q, state_d;
   logic         trigger_q, trigger_d;
   logic [7:0]   data_q, data_d;
   logic         line_start_q, line_start_d;
   logic         frame_start_q, frame_start_d;
   logic [15:0]  drop_count_q, drop_count_d;
   logic         frame_err_q, frame_err_d;

   // Positions widened to 32 bits so comparisons against the parameters are
   // exact even when H_ACTIVE/V_ACTIVE equal 2^width.
   logic [31:0] h32, v32;
   logic        px_sel, px_origin, px_last;

   logic        wr_req, wr_en, rd_en, drop;
   logic        fifo_empty, fifo_full;
   fifo_entry_t wr_entry, rd_entry;

   assign h32 = 32'(pixel_hcount_in);
   assign v32 = 32'(pixel_vcount_in);

   assign px_sel = pixel_valid_in && (h32 < H_ACTIVE) && (v32 < V_ACTIVE)
                && ((h32 & DECIM_MASK) == 32'd0) && ((v32 & DECIM_MASK) == 32'd0);
   assign px_origin = px_sel && (h32 == 32'd0) && (v32 == 32'd0);
   assign px_last   = px_sel && (h32 == H_ACTIVE - STEP) && (v32 == V_ACTIVE - STEP);

   assign wr_entry.sof  = px_origin;
   assign wr_entry.sol  = (h32 == 32'd0);
   assign wr_entry.data = pixel_data_in;

   // Issue rule: at most one pop every other cycle, so a trigger is always a
   // single-cycle pulse even with the sender held ready.
   assign rd_en = !fifo_empty && sender_ready_in && !trigger_q;
   assign wr_en = wr_req && (!fifo_full || rd_en);
   assign drop  = wr_req && !wr_en;

   always_comb begin
      state_d     = state_q;
      wr_req      = 1'b0;
      frame_err_d = frame_err_q;
      case (state_q)
         ST_IDLE: begin
            if (enable_in) state_d = ST_WAIT_FRAME;
         end
         ST_WAIT_FRAME: begin
            if (!enable_in) begin
               state_d = ST_IDLE;
            end else if (px_origin) begin
               state_d = ST_STREAM;
               wr_req  = 1'b1;
            end
         end
         ST_STREAM: begin
            // enable_in is ignored here; the frame always runs to its end.
            if (px_sel) begin
               wr_req = 1'b1;
               if (px_origin) frame_err_d = 1'b1;
               if (px_last)   state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) state_d = enable_in ? ST_WAIT_FRAME : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      trigger_d     = rd_en;
      data_d        = data_q;
      line_start_d  = line_start_q;
      frame_start_d = frame_start_q;
      drop_count_d  = drop_count_q;
      if (rd_en) begin
         data_d        = rd_entry.data;
         line_start_d  = rd_entry.sol;
         frame_start_d = rd_entry.sof;
      end
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= ST_IDLE;
         trigger_q     <= 1'b0;
         data_q        <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         drop_count_q  <= '0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         trigger_q     <= trigger_d;
         data_q        <= data_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         drop_count_q  <= drop_count_d;
         frame_err_q   <= frame_err_d;
      end
   end

   sched_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .wr_en_in    (wr_en),
      .wr_data_in  (wr_entry),
      .rd_en_in    (rd_en),
      .rd_data_out (rd_entry),
      .empty_out   (fifo_empty),
      .full_out    (fifo_full)
   );

   assign trigger_out     = trigger_q;
   assign data_out        = data_q;
   assign line_start_out  = line_start_q;
   assign frame_start_out = frame_start_q;
   assign drop_count_out  = drop_count_q;
   assign frame_err_out   = frame_err_q;
   assign state_out       = state_q;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_scheduler
// Small 16x8 frame, decimation 4 -> 8 selected pixels per frame (columns
// 0,4,8,12 of rows 0 and 4). Expected entries are queued when a pixel that
// must be accepted is driven, and popped on every trigger_out.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_frame_scheduler;
   import spi_link_pkg::*;

   localparam int TB_H   = 16;
   localparam int TB_V   = 8;
   localparam int TB_DL  = 2;
   localparam int TB_FD  = 16;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        enable_in;
   logic        pixel_valid_in;
   logic [9:0]  pixel_hcount_in;
   logic [8:0]  pixel_vcount_in;
   logic [7:0]  pixel_data_in;
   logic        sender_ready_in;
   logic        trigger_out;
   logic [7:0]  data_out;
   logic        line_start_out;
   logic        frame_start_out;
   logic [15:0] drop_count_out;
   logic        frame_err_out;
   logic [1:0]  state_out;

   spi_frame_scheduler #(
      .HCOUNT_WIDTH (10),
      .VCOUNT_WIDTH (9),
      .H_ACTIVE     (TB_H),
      .V_ACTIVE     (TB_V),
      .DECIM_LOG2   (TB_DL),
      .FIFO_DEPTH   (TB_FD)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .enable_in       (enable_in),
      .pixel_valid_in  (pixel_valid_in),
      .pixel_hcount_in (pixel_hcount_in),
      .pixel_vcount_in (pixel_vcount_in),
      .pixel_data_in   (pixel_data_in),
      .sender_ready_in (sender_ready_in),
      .trigger_out     (trigger_out),
      .data_out        (data_out),
      .line_start_out  (line_start_out),
      .frame_start_out (frame_start_out),
      .drop_count_out  (drop_count_out),
      .frame_err_out   (frame_err_out),
      .state_out       (state_out)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int trig_count;
   int last_trig_cyc;
   int first_trig_cyc;
   int first_wr_cyc;
   fifo_entry_t sb[$];

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every trigger must match the oldest expected entry.
   always @(negedge clk_in) begin
      if (!rst_in && trigger_out) begin
         check("trig_has_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            fifo_entry_t e;
            e = sb.pop_front();
            check("trig_data", 32'(data_out), 32'(e.data));
            check("trig_frame_start", 32'(frame_start_out), 32'(e.sof));
            check("trig_line_start", 32'(line_start_out), 32'(e.sol));
         end
         if (trig_count == 0) first_trig_cyc = cyc;
         else check("trig_gap_ge2", 32'((cyc - last_trig_cyc) >= 2), 32'd1);
         last_trig_cyc = cyc;
         trig_count++;
      end
   end

   function automatic bit is_sel(input int h, input int v);
      return (h < TB_H) && (v < TB_V) && (h % 4 == 0) && (v % 4 == 0);
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in); #1;
         pixel_valid_in = 1'b0;
      end
   endtask

   task automatic drive_px(input int h, input int v, input logic [7:0] d, input bit expect_wr);
      fifo_entry_t e;
      @(posedge clk_in); #1;
      pixel_valid_in  = 1'b1;
      pixel_hcount_in = 10'(h);
      pixel_vcount_in = 9'(v);
      pixel_data_in   = d;
      if (expect_wr) begin
         e.sof  = (h == 0) && (v == 0);
         e.sol  = (h == 0);
         e.data = d;
         sb.push_back(e);
      end
   endtask

   // Full raster including four columns past the active width; enable is
   // dropped with the first pixel of row drop_en_row (-1: never).
   task automatic scan_frame(input int drop_en_row);
      for (int v = 0; v < TB_V; v++) begin
         for (int h = 0; h < TB_H + 4; h++) begin
            drive_px(h, v, 8'(h * 3 + v * 17 + 1), is_sel(h, v));
            if (h == 0 && v == 0) first_wr_cyc = cyc;
            if (v == drop_en_row && h == 0) enable_in = 1'b0;
         end
      end
      idle(1);
   endtask

   task automatic wait_trigs(input int n, input int budget, input string tag);
      int k = 0;
      while (trig_count < n && k < budget) begin
         @(posedge clk_in); #1;
         k++;
      end
      check(tag, 32'(trig_count), 32'(n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in = 1'b1; enable_in = 1'b0; pixel_valid_in = 1'b0;
      pixel_hcount_in = '0; pixel_vcount_in = '0; pixel_data_in = '0;
      sender_ready_in = 1'b1; trig_count = 0; last_trig_cyc = 0;
      first_trig_cyc = 0; first_wr_cyc = 0;
      idle(3);
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_trigger", 32'(trigger_out), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_drop", 32'(drop_count_out), 32'd0);
      check("rst_err", 32'(frame_err_out), 32'd0);

      // Test 1: full frame, sender always ready.
      rst_in = 1'b0; enable_in = 1'b1;
      idle(2);
      check("t1_wait_frame", 32'(state_out), 32'd1);
      trig_count = 0;
      scan_frame(-1);
      wait_trigs(8, 50, "t1_trig_count");
      check("t1_latency", 32'(first_trig_cyc - first_wr_cyc), 32'd2);
      idle(4);
      check("t1_back_to_wait", 32'(state_out), 32'd1);
      check("t1_sb_empty", 32'(sb.size()), 32'd0);

      // Test 2: sender stalled; 24 selected pixels in STREAM, 16 buffered.
      sender_ready_in = 1'b0;
      trig_count = 0;
      drive_px(0, 0, 8'hA0, 1'b1);
      for (int i = 0; i < 22; i++) drive_px(4, 0, 8'(i + 1), sb.size() < TB_FD);
      drive_px(12, 4, 8'h5C, sb.size() < TB_FD);
      idle(2);
      check("t2_drop_count", 32'(drop_count_out), 32'd8);
      check("t2_drain", 32'(state_out), 32'd3);
      check("t2_no_trig_stalled", 32'(trig_count), 32'd0);
      sender_ready_in = 1'b1;
      wait_trigs(16, 80, "t2_trig_count");
      idle(4);
      check("t2_back_to_wait", 32'(state_out), 32'd1);

      // Test 3: enable dropped mid-frame; frame still completes.
      trig_count = 0;
      scan_frame(4);
      wait_trigs(8, 50, "t3_trig_count");
      idle(4);
      check("t3_idle", 32'(state_out), 32'd0);

      // Test 4: (0,0) re-injected mid-frame.
      enable_in = 1'b1;
      idle(3);
      check("t4_wait_frame", 32'(state_out), 32'd1);
      check("t4_err_clear", 32'(frame_err_out), 32'd0);
      trig_count = 0;
      drive_px(0, 0, 8'h11, 1'b1);
      drive_px(4, 0, 8'h22, 1'b1);
      drive_px(8, 0, 8'h33, 1'b1);
      drive_px(0, 0, 8'h44, 1'b1);
      idle(1);
      check("t4_err_set", 32'(frame_err_out), 32'd1);
      check("t4_still_stream", 32'(state_out), 32'd2);
      drive_px(12, 4, 8'h55, 1'b1);
      wait_trigs(5, 50, "t4_trig_count");
      idle(4);

      // Test 5: reset with five entries buffered.
      sender_ready_in = 1'b0;
      drive_px(0, 0, 8'h61, 1'b1);
      drive_px(4, 0, 8'h62, 1'b1);
      drive_px(8, 0, 8'h63, 1'b1);
      drive_px(12, 0, 8'h64, 1'b1);
      drive_px(0, 4, 8'h65, 1'b1);
      idle(2);
      check("t5_stream", 32'(state_out), 32'd2);
      @(posedge clk_in); #1;
      rst_in = 1'b1; sender_ready_in = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0; enable_in = 1'b0;
      sb.delete();
      trig_count = 0;
      idle(10);
      check("t5_no_trig", 32'(trig_count), 32'd0);
      check("t5_trigger", 32'(trigger_out), 32'd0);
      check("t5_data", 32'(data_out), 32'd0);
      check("t5_line_start", 32'(line_start_out), 32'd0);
      check("t5_frame_start", 32'(frame_start_out), 32'd0);
      check("t5_drop", 32'(drop_count_out), 32'd0);
      check("t5_err", 32'(frame_err_out), 32'd0);
      check("t5_state", 32'(state_out), 32'd0);

      // Test 6: saturate the drop counter (65540 drops).
      enable_in = 1'b1; sender_ready_in = 1'b0;
      idle(2);
      drive_px(0, 0, 8'h70, 1'b1);
      for (int i = 0; i < 15; i++) drive_px(4, 0, 8'(i), 1'b1);
      for (int i = 0; i < 100; i++) drive_px(4, 0, 8'hEE, 1'b0);
      idle(1);
      check("t6_drop_100", 32'(drop_count_out), 32'd100);
      for (int i = 0; i < 65440; i++) drive_px(4, 0, 8'hEE, 1'b0);
      idle(1);
      check("t6_drop_sat", 32'(drop_count_out), 32'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
